// File: rtl/sync_count_pkg.sv
// Shared types for the run-control sequencer and its JK toggle-chain counter.
package sync_count_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_e;

    // {J,K} command pairs applied to each counter stage
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_CLR  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    function automatic logic jk_next(input logic q, input logic [1:0] jk);
        logic r;
        case (jk)
            JK_HOLD: r = q;
            JK_CLR:  r = 1'b0;
            JK_SET:  r = 1'b1;
            JK_TGL:  r = ~q;
            default: r = q;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/jk_en_counter.sv
// WIDTH-bit synchronous up-counter built from a chain of JK stages.
// Stage i toggles when inc is high and all lower bits are 1; clr dominates.
module jk_en_counter
    import sync_count_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             carry_s;
    logic [1:0]       jk_s;

    // Per-stage JK command selection and next-state evaluation
    always_comb begin
        q_d     = q_q;
        carry_s = 1'b1;
        jk_s    = JK_HOLD;
        for (int i = 0; i < WIDTH; i++) begin
            if (clr) begin
                jk_s = JK_CLR;
            end else if (inc && carry_s) begin
                jk_s = JK_TGL;
            end else begin
                jk_s = JK_HOLD;
            end
            q_d[i]  = jk_next(q_q[i], jk_s);
            carry_s = carry_s & q_q[i];
        end
    end

    // Stage flip-flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= {WIDTH{1'b0}};
        end else begin
            q_q <= q_d;
        end
    end

    assign count = q_q;

endmodule

// File: rtl/sync_count_ctrl.sv
// Run-control sequencer: start/stop/pause, one-shot or periodic terminal count,
// driving the JK counter through inc/clr only.
module sync_count_ctrl
    import sync_count_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             periodic,
    input  logic [WIDTH-1:0] term,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] term_q;
    logic             periodic_q;
    logic             busy_q, done_q, wrap_q;
    logic             busy_d, done_d, wrap_d;
    logic             inc_s, clr_s, latch_s, at_term_s;

    assign at_term_s = (count == term_q);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; priority in RUN is stop > pause > terminal
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) state_d = RUN;
                else       state_d = IDLE;
            end
            RUN: begin
                if (stop)                         state_d = IDLE;
                else if (pause)                   state_d = HOLD;
                else if (at_term_s && !periodic_q) state_d = DONE;
                else                              state_d = RUN;
            end
            HOLD: begin
                if (stop)        state_d = IDLE;
                else if (!pause) state_d = RUN;
                else             state_d = HOLD;
            end
            default: state_d = IDLE;
        endcase
    end

    // Counter commands, latch enable and next values of the status flags
    always_comb begin
        inc_s   = 1'b0;
        clr_s   = 1'b0;
        latch_s = 1'b0;
        done_d  = 1'b0;
        wrap_d  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    latch_s = 1'b1;
                    clr_s   = 1'b1;
                end else begin
                    latch_s = 1'b0;
                end
            end
            RUN: begin
                if (stop) begin
                    clr_s = 1'b1;
                end else if (pause) begin
                    inc_s = 1'b0;
                end else if (at_term_s) begin
                    if (periodic_q) begin
                        clr_s  = 1'b1;
                        wrap_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end else begin
                    inc_s = 1'b1;
                end
            end
            HOLD: begin
                if (stop) clr_s = 1'b1;
                else      clr_s = 1'b0;
            end
            default: clr_s = 1'b1;
        endcase
        busy_d = (state_d == RUN) || (state_d == HOLD);
    end

    // Run configuration captured only on an accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            term_q     <= {WIDTH{1'b0}};
            periodic_q <= 1'b0;
        end else if (latch_s) begin
            term_q     <= term;
            periodic_q <= periodic;
        end else begin
            term_q     <= term_q;
            periodic_q <= periodic_q;
        end
    end

    // Registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            wrap_q <= wrap_d;
        end
    end

    jk_en_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_s),
        .clr   (clr_s),
        .count (count)
    );

    assign busy = busy_q;
    assign done = done_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_sync_count_ctrl.sv
// Table-driven bench for sync_count_ctrl plus a hand-written async reset sequence.
module tb_sync_count_ctrl;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             start, stop, pause, periodic;
    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] count;
    logic             busy, done, wrap;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       start, stop, pause, periodic;
        logic [3:0] term;
        logic [3:0] e_count;
        logic       e_busy, e_done, e_wrap;
    } vec_t;

    vec_t vecs[$];

    sync_count_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .pause    (pause),
        .periodic (periodic),
        .term     (term),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic st, input logic p, input logic per,
                       input logic [3:0] t, input logic [3:0] ec,
                       input logic eb, input logic ed, input logic ew);
        vec_t v;
        v.start = s; v.stop = st; v.pause = p; v.periodic = per; v.term = t;
        v.e_count = ec; v.e_busy = eb; v.e_done = ed; v.e_wrap = ew;
        vecs.push_back(v);
    endtask

    task automatic nop(input logic [3:0] ec, input logic eb, input logic ed, input logic ew);
        add(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, ec, eb, ed, ew);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; periodic = 1'b0; term = 4'd0;
        #12;
        check("reset count", count, 4'd0);
        check("reset busy", {3'd0, busy}, 4'd0);
        check("reset done", {3'd0, done}, 4'd0);
        check("reset wrap", {3'd0, wrap}, 4'd0);
        @(negedge clk) rst_n = 1'b1;

        // one-shot term=5, then stop in IDLE is ignored
        add(1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 4'd0, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) nop(4'(k), 1'b1, 1'b0, 1'b0);
        nop(4'd5, 1'b0, 1'b1, 1'b0);
        nop(4'd5, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd5, 1'b0, 1'b0, 1'b0);
        // periodic term=2
        add(1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 4'd0, 1'b1, 1'b0, 1'b0);
        for (int r = 0; r < 3; r++) begin
            nop(4'd1, 1'b1, 1'b0, 1'b0);
            nop(4'd2, 1'b1, 1'b0, 1'b0);
            nop(4'd0, 1'b1, 1'b0, 1'b1);
        end
        add(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        // pause at 4 for three cycles, resume, stop at 7
        add(1'b1, 1'b0, 1'b0, 1'b0, 4'd9, 4'd0, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) nop(4'(k), 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) add(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd4, 1'b1, 1'b0, 1'b0);
        nop(4'd4, 1'b1, 1'b0, 1'b0);
        for (int k = 5; k <= 7; k++) nop(4'(k), 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        nop(4'd0, 1'b0, 1'b0, 1'b0);
        // stop and pause together in RUN
        add(1'b1, 1'b0, 1'b0, 1'b0, 4'd9, 4'd0, 1'b1, 1'b0, 1'b0);
        nop(4'd1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        // stop while in HOLD
        add(1'b1, 1'b0, 1'b0, 1'b0, 4'd9, 4'd0, 1'b1, 1'b0, 1'b0);
        nop(4'd1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        // start during RUN must not relatch term/periodic
        add(1'b1, 1'b0, 1'b0, 1'b0, 4'd4, 4'd0, 1'b1, 1'b0, 1'b0);
        nop(4'd1, 1'b1, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 4'd2, 1'b1, 1'b0, 1'b0);
        nop(4'd3, 1'b1, 1'b0, 1'b0);
        nop(4'd4, 1'b1, 1'b0, 1'b0);
        nop(4'd4, 1'b0, 1'b1, 1'b0);
        nop(4'd4, 1'b0, 1'b0, 1'b0);
        // term=0 one-shot and periodic
        add(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        nop(4'd0, 1'b0, 1'b1, 1'b0);
        nop(4'd0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        nop(4'd0, 1'b1, 1'b0, 1'b1);
        nop(4'd0, 1'b1, 1'b0, 1'b1);
        add(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        // term=15, then back-to-back restart from DONE
        add(1'b1, 1'b0, 1'b0, 1'b0, 4'd15, 4'd0, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 15; k++) nop(4'(k), 1'b1, 1'b0, 1'b0);
        nop(4'd15, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 4'd0, 1'b1, 1'b0, 1'b0);
        nop(4'd1, 1'b1, 1'b0, 1'b0);
        nop(4'd2, 1'b1, 1'b0, 1'b0);
        nop(4'd2, 1'b0, 1'b1, 1'b0);
        nop(4'd2, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            start = vecs[i].start; stop = vecs[i].stop; pause = vecs[i].pause;
            periodic = vecs[i].periodic; term = vecs[i].term;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d count", i), count, vecs[i].e_count);
            check($sformatf("vec%0d busy", i), {3'd0, busy}, {3'd0, vecs[i].e_busy});
            check($sformatf("vec%0d done", i), {3'd0, done}, {3'd0, vecs[i].e_done});
            check($sformatf("vec%0d wrap", i), {3'd0, wrap}, {3'd0, vecs[i].e_wrap});
        end

        // asynchronous reset mid-run at count 6
        @(negedge clk);
        start = 1'b1; stop = 1'b0; pause = 1'b0; periodic = 1'b0; term = 4'd9;
        @(negedge clk);
        start = 1'b0; term = 4'd0;
        repeat (6) @(posedge clk);
        #1;
        check("pre-reset count", count, 4'd6);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async count", count, 4'd0);
        check("async busy", {3'd0, busy}, 4'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("post-reset done c%0d", k), {3'd0, done}, 4'd0);
            check($sformatf("post-reset wrap c%0d", k), {3'd0, wrap}, 4'd0);
            check($sformatf("post-reset count c%0d", k), count, 4'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sync_count_ctrl.md
Name: sync_count_ctrl

Overview:
Run-control sequencer for the synchronous JK-flip-flop counter datapath.
- Accepts start/stop/pause commands and a terminal count.
- Runs the counter in one-shot or periodic mode.
- Reports busy/done/wrap status.
- Sits between a control/CSR master and the counter, so software-visible timers can reuse the toggle-chain counter without driving J/K inputs directly.

Parameters:
WIDTH, 4, counter width in bits (2..16)

Ports:
clk       input   1      rising-edge clock
rst_n     input   1      asynchronous active-low reset
start     input   1      start request; accepted only in IDLE or DONE
stop      input   1      abort request; honoured in RUN or HOLD
pause     input   1      level; while high in RUN/HOLD, counter frozen
periodic  input   1      mode select, latched on accepted start (1 = auto-reload)
term      input   WIDTH  terminal count, latched on accepted start
count     output  WIDTH  current counter value
busy      output  1      high in RUN and HOLD
done      output  1      one-cycle pulse on one-shot completion
wrap      output  1      one-cycle pulse on periodic reload

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n). All state and outputs are registered.
- Reset values: state = IDLE, count = 0, busy = 0, done = 0, wrap = 0, term_q = 0, periodic_q = 0.
- States: IDLE, RUN, HOLD, DONE.
- IDLE:
  - start = 1 → latch term_q and periodic_q, clear count to 0, go to RUN.
  - Otherwise count holds its last value.
- RUN, per edge, priority stop > pause > terminal > increment:
  - stop → IDLE; count cleared to 0; no done, no wrap.
  - pause → HOLD; count holds.
  - count == term_q, periodic_q = 1 → count = 0, wrap = 1 for one cycle, stay in RUN.
  - count == term_q, periodic_q = 0 → DONE; count holds term_q; done = 1 for one cycle.
  - Otherwise count increments by 1.
- HOLD:
  - stop → IDLE; count cleared to 0.
  - pause low → RUN. Counting resumes on the following edge, so no increment occurs on the resume edge.
- DONE: lasts exactly one cycle, with done = 1 and busy = 0.
  - start in DONE → behaves as start in IDLE (back-to-back restart).
  - Otherwise → IDLE.
- Start latency and timing: start sampled at edge n gives count = 0 after n, count = k after n+k.
  - One-shot with term = T: count = T after edge n+T; done high for the cycle after edge n+T+1.
- Inputs ignored by state:
  - start in RUN/HOLD: ignored; term/periodic not relatched.
  - stop in IDLE/DONE: ignored.
- term = 0:
  - One-shot: DONE on the first RUN edge.
  - Periodic: wrap pulses every cycle and count stays 0.
- term = all ones: count reaches 2^WIDTH−1 and then completes/reloads. There is no free-running modulo overflow.
- Inputs are sampled only at edges; mid-run changes to term/periodic have no effect.
- rst_n asserted mid-operation: immediate return to reset values, with no done/wrap pulse emitted.
- Counter datapath:
  - Stage i toggles (J = K = 1) when inc = 1 and bits 0..i−1 are all 1.
  - Synchronous clear drives J = 0, K = 1 on all stages.
  - Hold drives J = K = 0.
  - Count is never loaded with arbitrary values.

Decomposition:
- Shared package (sync_count_pkg): state enum {IDLE, RUN, HOLD, DONE} encoded as 2 bits; localparam encodings for the JK command pairs (HOLD = 2'b00, CLR = 2'b01, SET = 2'b10, TGL = 2'b11).
- One sub-module: jk_en_counter.
  - WIDTH-bit synchronous JK counter with inputs inc and clr (clr dominant) and asynchronous active-low reset.
  - Built as a chain of JK stages.
  - The controller FSM is the top level and drives inc/clr.

Test Plan:
- One-shot: reset, term = 5, periodic = 0, start pulse at cycle 0 → count 0,1,2,3,4,5 on cycles 1–6; done = 1 only on cycle 7; busy high cycles 1–6; count stays 5 in IDLE.
- Periodic: term = 2, periodic = 1, start → count 0,1,2,0,1,2,…; wrap = 1 exactly on each cycle count returns to 0 (every 3rd cycle after the first reload); done never asserts.
- Pause/stop: term = 9 one-shot, pause high for 3 cycles at count = 4 → count stays 4 for the HOLD cycles, then resumes 5,6…; stop at count = 7 → next cycle IDLE, count = 0, busy = 0, no done.
- Priority/ignore: stop and pause both high in RUN → IDLE, count 0. start with term = 3 during RUN → term_q unchanged, run completes at the original term.
- Edges:
  - term = 0 one-shot → done on the 2nd cycle after start.
  - WIDTH = 4, term = 15 → count reaches 15, then done.
  - start asserted during DONE → new run starts with count = 0 the next cycle.
- Async reset: rst_n low mid-run at count = 6 → count = 0, busy = 0 immediately (before the next clk edge); no done/wrap after release.
